// File: rtl/rename_map_if.sv
// Rename-group and commit signals exchanged between dispatch, ROB, free list and the
// register alias table. The master drives the requests and the slave (the map) answers.
interface rename_map_if #(
  parameter int ARCH_SEL = 5,
  parameter int PHY_SEL  = 6
);
  logic                stall_DP;
  logic                prmiss;
  logic                invalid1;
  logic                invalid2;
  logic                wr_reg_1;
  logic                wr_reg_2;
  logic [ARCH_SEL-1:0] dst1;
  logic [ARCH_SEL-1:0] dst2;
  logic [ARCH_SEL-1:0] src1a;
  logic [ARCH_SEL-1:0] src1b;
  logic [ARCH_SEL-1:0] src2a;
  logic [ARCH_SEL-1:0] src2b;
  logic [PHY_SEL-1:0]  phy_dst1;
  logic [PHY_SEL-1:0]  phy_dst2;
  logic                allocatable;
  logic                com_en1;
  logic                com_en2;
  logic [ARCH_SEL-1:0] com_dst1;
  logic [ARCH_SEL-1:0] com_dst2;
  logic [PHY_SEL-1:0]  com_phy1;
  logic [PHY_SEL-1:0]  com_phy2;
  logic [PHY_SEL-1:0]  ps1a;
  logic [PHY_SEL-1:0]  ps1b;
  logic [PHY_SEL-1:0]  ps2a;
  logic [PHY_SEL-1:0]  ps2b;
  logic [PHY_SEL-1:0]  old_pd1;
  logic [PHY_SEL-1:0]  old_pd2;
  logic                rename_fire;

  modport master (
    output stall_DP, prmiss, invalid1, invalid2, wr_reg_1, wr_reg_2,
           dst1, dst2, src1a, src1b, src2a, src2b, phy_dst1, phy_dst2, allocatable,
           com_en1, com_en2, com_dst1, com_dst2, com_phy1, com_phy2,
    input  ps1a, ps1b, ps2a, ps2b, old_pd1, old_pd2, rename_fire
  );

  modport slave (
    input  stall_DP, prmiss, invalid1, invalid2, wr_reg_1, wr_reg_2,
           dst1, dst2, src1a, src1b, src2a, src2b, phy_dst1, phy_dst2, allocatable,
           com_en1, com_en2, com_dst1, com_dst2, com_phy1, com_phy2,
    output ps1a, ps1b, ps2a, ps2b, old_pd1, old_pd2, rename_fire
  );
endinterface

// File: rtl/rename_map.sv
// 2-wide register alias table: speculative map renamed by dispatch, committed map
// written by the ROB and copied back into the speculative map on a mispredict.
module rename_map #(
  parameter int ARCH_REG_NUM = 32,
  parameter int ARCH_SEL     = 5,
  parameter int PHY_REG_NUM  = 64,
  parameter int PHY_SEL      = 6
) (
  input  logic         clk,
  input  logic         reset,
  rename_map_if.slave  rm
);

  // Identity reset maps arch i to phy i, so the physical file must cover every arch reg.
  if (ARCH_REG_NUM > PHY_REG_NUM || PHY_REG_NUM > (1 << PHY_SEL)) begin : g_bad_params
    $error("rename_map: inconsistent register-count parameters");
  end

  logic [PHY_SEL-1:0] spec_map_q [ARCH_REG_NUM];
  logic [PHY_SEL-1:0] spec_map_d [ARCH_REG_NUM];
  logic [PHY_SEL-1:0] com_map_q  [ARCH_REG_NUM];
  logic [PHY_SEL-1:0] com_map_d  [ARCH_REG_NUM];

  logic we1;
  logic we2;
  logic fire;

  assign we1  = ~rm.invalid1 & rm.wr_reg_1 & (rm.dst1 != '0);
  assign we2  = ~rm.invalid2 & rm.wr_reg_2 & (rm.dst2 != '0);
  assign fire = ~rm.stall_DP & ~rm.prmiss & rm.allocatable & ~(rm.invalid1 & rm.invalid2);

  // Arch reg 0 is forced to tag 0 on every read port, independent of map contents.
  assign rm.ps1a = (rm.src1a == '0) ? '0 : spec_map_q[rm.src1a];
  assign rm.ps1b = (rm.src1b == '0) ? '0 : spec_map_q[rm.src1b];

  // Slot 2 must see slot 1's new tag when it reads or overwrites slot 1's destination.
  assign rm.ps2a = (we1 && rm.src2a == rm.dst1) ? rm.phy_dst1 :
                   (rm.src2a == '0) ? '0 : spec_map_q[rm.src2a];
  assign rm.ps2b = (we1 && rm.src2b == rm.dst1) ? rm.phy_dst1 :
                   (rm.src2b == '0) ? '0 : spec_map_q[rm.src2b];

  assign rm.old_pd1 = (rm.dst1 == '0) ? '0 : spec_map_q[rm.dst1];
  assign rm.old_pd2 = (we1 && rm.dst2 == rm.dst1) ? rm.phy_dst1 :
                      (rm.dst2 == '0) ? '0 : spec_map_q[rm.dst2];

  assign rm.rename_fire = fire;

  // NOTE: blocking assignments in always_comb build next-state in program order, so the
  // later slot-2 write overrides slot 1 when both target the same entry.
  always_comb begin
    com_map_d = com_map_q;
    if (rm.com_en1 && rm.com_dst1 != '0) com_map_d[rm.com_dst1] = rm.com_phy1;
    if (rm.com_en2 && rm.com_dst2 != '0) com_map_d[rm.com_dst2] = rm.com_phy2;

    spec_map_d = spec_map_q;
    if (rm.prmiss) begin
      // Restore from the committed map including this cycle's commits.
      spec_map_d = com_map_d;
    end else if (fire) begin
      if (we1) spec_map_d[rm.dst1] = rm.phy_dst1;
      if (we2) spec_map_d[rm.dst2] = rm.phy_dst2;
    end
  end

  // NOTE: both maps are flop arrays that need a defined identity state, so every entry is
  // reset explicitly; a RAM macro without reset could not satisfy this.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REG_NUM; i++) begin
        spec_map_q[i] <= PHY_SEL'(i);
        com_map_q[i]  <= PHY_SEL'(i);
      end
    end else begin
      spec_map_q <= spec_map_d;
      com_map_q  <= com_map_d;
    end
  end

endmodule

// File: tb/tb_rename_map.sv
// Self-checking bench for rename_map: directed scenarios followed by random traffic,
// all compared against a table-level model of the speculative and committed maps.
module tb_rename_map;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  // Reference maps: plain integer tables updated from the architectural rules.
  int spec_m [32];
  int com_m  [32];

  rename_map_if #(.ARCH_SEL(5), .PHY_SEL(6)) rif ();

  rename_map #(
    .ARCH_REG_NUM(32),
    .ARCH_SEL    (5),
    .PHY_REG_NUM (64),
    .PHY_SEL     (6)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rm   (rif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit model_we1();
    return !rif.invalid1 && rif.wr_reg_1 && (rif.dst1 != 0);
  endfunction

  function automatic bit model_we2();
    return !rif.invalid2 && rif.wr_reg_2 && (rif.dst2 != 0);
  endfunction

  function automatic bit model_fire();
    return !rif.stall_DP && !rif.prmiss && rif.allocatable && !(rif.invalid1 && rif.invalid2);
  endfunction

  // Tag slot 2 should see for arch reg a: slot 1's new tag if slot 1 writes a, else the map.
  function automatic int slot2_view(input int a);
    if (model_we1() && a == int'(rif.dst1)) return int'(rif.phy_dst1);
    return spec_m[a];
  endfunction

  task automatic clear_inputs();
    rif.stall_DP    = 1'b0;
    rif.prmiss      = 1'b0;
    rif.invalid1    = 1'b1;
    rif.invalid2    = 1'b1;
    rif.wr_reg_1    = 1'b0;
    rif.wr_reg_2    = 1'b0;
    rif.dst1        = '0;
    rif.dst2        = '0;
    rif.src1a       = '0;
    rif.src1b       = '0;
    rif.src2a       = '0;
    rif.src2b       = '0;
    rif.phy_dst1    = '0;
    rif.phy_dst2    = '0;
    rif.allocatable = 1'b1;
    rif.com_en1     = 1'b0;
    rif.com_en2     = 1'b0;
    rif.com_dst1    = '0;
    rif.com_dst2    = '0;
    rif.com_phy1    = '0;
    rif.com_phy2    = '0;
  endtask

  // Compare every combinational output against the model, a little after the inputs settle.
  task automatic eval_outputs();
    #1;
    check("ps1a", 8'(rif.ps1a), 8'(spec_m[rif.src1a]));
    check("ps1b", 8'(rif.ps1b), 8'(spec_m[rif.src1b]));
    check("ps2a", 8'(rif.ps2a), 8'(slot2_view(int'(rif.src2a))));
    check("ps2b", 8'(rif.ps2b), 8'(slot2_view(int'(rif.src2b))));
    check("old_pd1", 8'(rif.old_pd1), 8'(spec_m[rif.dst1]));
    check("old_pd2", 8'(rif.old_pd2), 8'(slot2_view(int'(rif.dst2))));
    check("rename_fire", 8'(rif.rename_fire), 8'(model_fire()));
  endtask

  // Advance one clock, applying the same update to the model, then return at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        spec_m[i] = i;
        com_m[i]  = i;
      end
    end else begin
      if (rif.com_en1 && rif.com_dst1 != 0) com_m[rif.com_dst1] = int'(rif.com_phy1);
      if (rif.com_en2 && rif.com_dst2 != 0) com_m[rif.com_dst2] = int'(rif.com_phy2);
      if (rif.prmiss) begin
        spec_m = com_m;
      end else if (model_fire()) begin
        if (model_we1()) spec_m[rif.dst1] = int'(rif.phy_dst1);
        if (model_we2()) spec_m[rif.dst2] = int'(rif.phy_dst2);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Identity lookup straight after reset.
    rif.invalid1 = 1'b0;
    rif.src1a    = 5'd5;
    rif.src2b    = 5'd31;
    rif.dst1     = 5'd9;
    eval_outputs();
    check("reset_ps1a", 8'(rif.ps1a), 8'd5);
    check("reset_ps2b", 8'(rif.ps2b), 8'd31);
    check("reset_old_pd1", 8'(rif.old_pd1), 8'd9);
    check("reset_fire", 8'(rif.rename_fire), 8'd1);
    tick();

    // Both slots write arch 3; slot 2 reads it through the bypass.
    clear_inputs();
    rif.invalid1 = 1'b0;  rif.invalid2 = 1'b0;
    rif.wr_reg_1 = 1'b1;  rif.wr_reg_2 = 1'b1;
    rif.dst1 = 5'd3;  rif.phy_dst1 = 6'd40;
    rif.dst2 = 5'd3;  rif.phy_dst2 = 6'd41;
    rif.src2a = 5'd3;
    eval_outputs();
    check("bypass_ps2a", 8'(rif.ps2a), 8'd40);
    check("bypass_old_pd1", 8'(rif.old_pd1), 8'd3);
    check("bypass_old_pd2", 8'(rif.old_pd2), 8'd40);
    tick();
    clear_inputs();
    rif.invalid1 = 1'b0;
    rif.src1a    = 5'd3;
    eval_outputs();
    check("slot2_wins", 8'(rif.ps1a), 8'd41);
    tick();

    // Arch reg 0 is never remapped.
    clear_inputs();
    rif.invalid1 = 1'b0;  rif.wr_reg_1 = 1'b1;
    rif.dst1 = 5'd0;  rif.phy_dst1 = 6'd50;
    eval_outputs();
    tick();
    clear_inputs();
    rif.invalid1 = 1'b0;
    rif.src1a = 5'd0;  rif.src2a = 5'd0;
    eval_outputs();
    check("r0_ps1a", 8'(rif.ps1a), 8'd0);
    tick();

    // Stall, then no allocation: no rename of arch 7.
    clear_inputs();
    rif.invalid1 = 1'b0;  rif.wr_reg_1 = 1'b1;
    rif.dst1 = 5'd7;  rif.phy_dst1 = 6'd45;
    rif.stall_DP = 1'b1;
    eval_outputs();
    check("stall_fire", 8'(rif.rename_fire), 8'd0);
    tick();
    rif.stall_DP    = 1'b0;
    rif.allocatable = 1'b0;
    eval_outputs();
    check("noalloc_fire", 8'(rif.rename_fire), 8'd0);
    tick();
    clear_inputs();
    rif.invalid1 = 1'b0;
    rif.src1a = 5'd7;
    eval_outputs();
    check("stall_hold", 8'(rif.ps1a), 8'd7);
    tick();

    // Rename 7 and 8, commit only 7, mispredict with a same-cycle commit of 9.
    clear_inputs();
    rif.invalid1 = 1'b0;  rif.invalid2 = 1'b0;
    rif.wr_reg_1 = 1'b1;  rif.wr_reg_2 = 1'b1;
    rif.dst1 = 5'd7;  rif.phy_dst1 = 6'd45;
    rif.dst2 = 5'd8;  rif.phy_dst2 = 6'd46;
    eval_outputs();
    tick();
    clear_inputs();
    rif.com_en1 = 1'b1;  rif.com_dst1 = 5'd7;  rif.com_phy1 = 6'd45;
    eval_outputs();
    tick();
    clear_inputs();
    rif.prmiss  = 1'b1;
    rif.stall_DP = 1'b1;
    rif.com_en2 = 1'b1;  rif.com_dst2 = 5'd9;  rif.com_phy2 = 6'd47;
    rif.invalid1 = 1'b0;  rif.wr_reg_1 = 1'b1;
    rif.dst1 = 5'd10;  rif.phy_dst1 = 6'd60;
    eval_outputs();
    check("prmiss_fire", 8'(rif.rename_fire), 8'd0);
    tick();
    clear_inputs();
    rif.invalid1 = 1'b0;  rif.invalid2 = 1'b0;
    rif.src1a = 5'd7;  rif.src1b = 5'd8;  rif.src2a = 5'd9;  rif.src2b = 5'd10;
    eval_outputs();
    check("restore_7", 8'(rif.ps1a), 8'd45);
    check("restore_8", 8'(rif.ps1b), 8'd8);
    check("restore_9", 8'(rif.ps2a), 8'd47);
    check("restore_10", 8'(rif.ps2b), 8'd10);
    tick();

    // Same-register commit on both slots, then mispredict.
    clear_inputs();
    rif.com_en1 = 1'b1;  rif.com_dst1 = 5'd4;  rif.com_phy1 = 6'd20;
    rif.com_en2 = 1'b1;  rif.com_dst2 = 5'd4;  rif.com_phy2 = 6'd21;
    eval_outputs();
    tick();
    clear_inputs();
    rif.prmiss = 1'b1;
    eval_outputs();
    tick();
    clear_inputs();
    rif.invalid1 = 1'b0;
    rif.src1a = 5'd4;
    eval_outputs();
    check("com_slot2_wins", 8'(rif.ps1a), 8'd21);
    tick();

    // Random traffic with occasional collisions, mispredicts and resets.
    for (int n = 0; n < 400; n++) begin
      reset            = ($urandom_range(63) == 0);
      rif.stall_DP     = ($urandom_range(4) == 0);
      rif.prmiss       = ($urandom_range(9) == 0);
      rif.allocatable  = ($urandom_range(4) != 0);
      rif.invalid1     = ($urandom_range(5) == 0);
      rif.invalid2     = ($urandom_range(3) == 0);
      rif.wr_reg_1     = ($urandom_range(3) != 0);
      rif.wr_reg_2     = ($urandom_range(3) != 0);
      rif.dst1         = 5'($urandom);
      rif.dst2         = ($urandom_range(3) == 0) ? rif.dst1 : 5'($urandom);
      rif.src1a        = 5'($urandom);
      rif.src1b        = 5'($urandom);
      rif.src2a        = ($urandom_range(2) == 0) ? rif.dst1 : 5'($urandom);
      rif.src2b        = ($urandom_range(3) == 0) ? rif.dst1 : 5'($urandom);
      rif.phy_dst1     = 6'($urandom);
      rif.phy_dst2     = 6'($urandom);
      rif.com_en1      = ($urandom_range(1) == 0);
      rif.com_en2      = ($urandom_range(1) == 0);
      rif.com_dst1     = 5'($urandom);
      rif.com_dst2     = ($urandom_range(4) == 0) ? rif.com_dst1 : 5'($urandom);
      rif.com_phy1     = 6'($urandom);
      rif.com_phy2     = 6'($urandom);
      eval_outputs();
      tick();
    end

    // Reset in the middle of traffic: both maps return to identity.
    clear_inputs();
    rif.invalid1 = 1'b0;  rif.wr_reg_1 = 1'b1;
    rif.dst1 = 5'd12;  rif.phy_dst1 = 6'd55;
    rif.com_en1 = 1'b1;  rif.com_dst1 = 5'd13;  rif.com_phy1 = 6'd56;
    reset = 1'b1;
    eval_outputs();
    tick();
    reset = 1'b0;
    clear_inputs();
    rif.invalid1 = 1'b0;
    rif.src1a = 5'd12;  rif.src1b = 5'd13;
    eval_outputs();
    check("rst_spec_12", 8'(rif.ps1a), 8'd12);
    tick();
    clear_inputs();
    rif.prmiss = 1'b1;
    eval_outputs();
    tick();
    clear_inputs();
    rif.invalid1 = 1'b0;
    rif.src1a = 5'd13;  rif.src1b = 5'd3;
    eval_outputs();
    check("rst_com_13", 8'(rif.ps1a), 8'd13);
    check("rst_com_3", 8'(rif.ps1b), 8'd3);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rename_map.md
Name: rename_map

Overview:
- 2-wide register alias table in the rename stage.
- Consumes the two physical destination tags and `allocatable` from the free list, and updates the speculative architectural-to-physical map.
- Supplies physical source tags and previous destination mappings (old_pd) to dispatch/ROB. ROB later returns old_pd as released tags.
- Keeps a committed map, updated by ROB commit, which restores the speculative map on branch misprediction (prmiss).

Parameters:
ARCH_REG_NUM, 32, number of architectural registers
ARCH_SEL, 5, architectural tag width
PHY_REG_NUM, 64, number of physical registers
PHY_SEL, 6, physical tag width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
stall_DP  in  1  dispatch stall; blocks rename update
prmiss  in  1  branch mispredict; restore speculative map
invalid1, invalid2  in  1  slot k holds no instruction
wr_reg_1, wr_reg_2  in  1  slot k writes a destination
dst1, dst2  in  ARCH_SEL  architectural destinations
src1a, src1b, src2a, src2b  in  ARCH_SEL  architectural sources, slots 1/2
phy_dst1, phy_dst2  in  PHY_SEL  allocated tags from free list
allocatable  in  1  free list can satisfy this cycle's request
com_en1, com_en2  in  1  ROB commit of a register-writing instruction
com_dst1, com_dst2  in  ARCH_SEL  committed architectural destination
com_phy1, com_phy2  in  PHY_SEL  committed physical destination
ps1a, ps1b, ps2a, ps2b  out  PHY_SEL  physical source tags
old_pd1, old_pd2  out  PHY_SEL  previous mapping of dstk
rename_fire  out  1  rename group accepted this cycle

Behaviour:
- State:
  - spec_map[ARCH_REG_NUM] and com_map[ARCH_REG_NUM], each PHY_SEL wide.
  - Flop arrays or register files with 4+2 combinational reads; no pipeline register on outputs.
- Reset: both maps hold identity (arch i -> phy i). Reset has priority over all other inputs.
- Write enables:
  - we1 = ~invalid1 & wr_reg_1 & (dst1 != 0); we2 likewise.
  - Arch reg 0 is never remapped; reads of 0 always return 0.
- rename_fire = ~stall_DP & ~prmiss & allocatable & ~(invalid1 & invalid2).
- Source lookup (combinational):
  - ps1a/ps1b = spec_map[src].
  - ps2a/ps2b = phy_dst1 if we1 and src == dst1 (intra-group bypass), else spec_map[src].
- old_pd1 = spec_map[dst1].
- old_pd2 = phy_dst1 if we1 and dst2 == dst1, else spec_map[dst2].
- Outputs are meaningful only when rename_fire=1; otherwise values are don't-care but must be deterministic (no X from map).
- Speculative update, at posedge when rename_fire:
  - spec_map[dst1] <= phy_dst1 if we1.
  - spec_map[dst2] <= phy_dst2 if we2.
  - If dst1 == dst2 and both writing, slot 2 wins.
- Committed update, every cycle regardless of stall_DP/prmiss:
  - com_map[com_dstk] <= com_phyk if com_enk and com_dstk != 0.
  - If com_dst1 == com_dst2, slot 2 wins.
- prmiss:
  - spec_map <= next-state com_map, i.e. including this cycle's commits with the same slot-2-wins rule.
  - No speculative rename update that cycle.
  - prmiss overrides stall_DP.
- Stall / not allocatable: spec_map holds; commits still update com_map.
- Only slot 1 valid: slot 2 contributes nothing (we2=0, no bypass effect on slot 1).
- Free list interface: rename_fire is the free list's allocation acknowledge. Tags are consumed only when rename_fire=1.

Test Plan:
- Reset, then read src1a=5, src2b=31 -> ps1a=5, ps2b=31, old_pd1=dst1 index; rename_fire=1 with allocatable=1, stall_DP=0.
- Slot1 dst1=3 phy_dst1=40, slot2 src2a=3, dst2=3 phy_dst2=41, fire -> ps2a=40, old_pd1=3, old_pd2=40; next cycle src1a=3 reads 41.
- dst1=0 with wr_reg_1=1, phy_dst1=50, fire -> spec_map[0] stays 0; next lookup src=0 returns 0.
- Rename dst1=7->45 with stall_DP=1 or allocatable=0 -> rename_fire=0, next cycle src=7 returns 7.
- Rename 7->45 and 8->46; commit 7->45 only; assert prmiss with same-cycle commit com_dst2=9 com_phy2=47 -> next cycle src 7=45, 8=8, 9=47; no rename in prmiss cycle.
- com_dst1=com_dst2=4 with com_phy1=20, com_phy2=21, then prmiss -> spec_map[4]=21; reset asserted mid-sequence -> all maps identity next cycle.
